seq_detect_ctrl: RTL

//  Controller that serialises parallel words into the overlapping "1010" Mealy sequence detector.

---
 rtl/seq_detect_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Serialises parallel words MSB-first into an external overlapping "1010" Mealy detector,
// collecting a per-word saturating hit count and hit-position mask.
module seq_detect_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              det_bit,
    output logic              det_reset,
    input  logic              det_hit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [WORD_W-1:0] hit_mask
);

    localparam int unsigned K_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [K_W-1:0]      rev_idx;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [WORD_W-1:0]   hit_mask_q, hit_mask_d;
    logic                in_ready_q, in_ready_d;
    logic                det_bit_q, det_bit_d;
    logic                det_reset_q, det_reset_d;
    logic                out_valid_q, out_valid_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            k_q         <= '0;
            hit_count_q <= '0;
            hit_mask_q  <= '0;
            in_ready_q  <= 1'b0;
            det_bit_q   <= 1'b0;
            det_reset_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            k_q         <= k_d;
            hit_count_q <= hit_count_d;
            hit_mask_q  <= hit_mask_d;
            in_ready_q  <= in_ready_d;
            det_bit_q   <= det_bit_d;
            det_reset_q <= det_reset_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state; outputs are precomputed from the next state so they come straight off flops
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        k_d         = k_q;
        hit_count_d = hit_count_q;
        hit_mask_d  = hit_mask_q;
        rev_idx     = K_LAST - k_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d     = in_word;
                    k_d         = '0;
                    hit_count_d = '0;
                    hit_mask_d  = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Rotate rather than shift so the MSB stays referenced; only bits still to send matter
                shreg_d = {shreg_q[WORD_W-2:0], shreg_q[WORD_W-1]};
                k_d     = k_q + K_W'(1);
                if (det_hit) begin
                    if (hit_count_q != CNT_MAX) begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end
                    hit_mask_d[rev_idx] = 1'b1;
                end
                if (k_q == K_LAST) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_RESULT);
        det_reset_d = (state_d != ST_SHIFT);
        det_bit_d   = (state_d == ST_SHIFT) ? shreg_d[WORD_W-1] : 1'b0;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign det_reset = det_reset_q;
    assign det_bit   = det_bit_q;
    assign hit_count = hit_count_q;
    assign hit_mask  = hit_mask_q;

endmodule
